// File: rtl/piso_stream.sv
// Parallel-in / serial-out serializer with a one-word holding buffer, valid/ready load
// handshake, selectable bit order and a shift enable for baud-rate pacing.
module piso_stream #(
    parameter int   WIDTH      = 8,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] par_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             shift_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             word_done,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] hold;
    logic [CNT_W-1:0] cnt;
    logic             loaded;
    logic             hold_full;

    logic             accept;
    logic             consume;
    logic             last_bit;

    // Move the word one place toward the output bit, filling the vacated end with zero.
    function automatic logic [WIDTH-1:0] shift_toward_out(input logic [WIDTH-1:0] word);
        if (MSB_FIRST)
            return {word[WIDTH-2:0], 1'b0};
        else
            return {1'b0, word[WIDTH-1:1]};
    endfunction

    function automatic logic out_bit(input logic [WIDTH-1:0] word);
        if (MSB_FIRST)
            return word[WIDTH-1];
        else
            return word[0];
    endfunction

    always_comb begin
        accept   = in_valid & ~hold_full;
        consume  = loaded & shift_en;
        last_bit = consume & (cnt == CNT_LAST);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shreg     <= '0;
            hold      <= '0;
            cnt       <= '0;
            loaded    <= 1'b0;
            hold_full <= 1'b0;
            word_done <= 1'b0;
        end else begin
            word_done <= last_bit;
            if (last_bit) begin
                // Refill from hold first; a direct accept only happens when hold is empty,
                // which keeps back-to-back words gapless.
                cnt <= '0;
                if (hold_full) begin
                    shreg     <= hold;
                    hold_full <= 1'b0;
                end else if (accept) begin
                    shreg <= par_in;
                end else begin
                    loaded <= 1'b0;
                end
            end else begin
                if (consume) begin
                    shreg <= shift_toward_out(shreg);
                    cnt   <= cnt + CNT_ONE;
                end
                if (accept) begin
                    if (!loaded) begin
                        shreg  <= par_in;
                        cnt    <= '0;
                        loaded <= 1'b1;
                    end else begin
                        hold      <= par_in;
                        hold_full <= 1'b1;
                    end
                end
            end
        end
    end

    // All outputs are decoded from flops only; no input reaches them combinationally.
    always_comb begin
        ser_valid   = loaded;
        ser_out     = loaded ? out_bit(shreg) : IDLE_LEVEL;
        in_ready    = ~hold_full;
        frame_start = loaded & (cnt == '0);
        frame_end   = loaded & (cnt == CNT_LAST);
        busy        = loaded | hold_full;
    end

endmodule

// File: tb/tb_piso_stream.sv
// Directed bench for piso_stream: an MSB-first instance and an LSB-first, idle-high instance
// driven from the same stimulus.
module tb_piso_stream;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] par_in = 8'h00;
    logic       in_valid = 1'b0;
    logic       shift_en = 1'b0;

    logic m_in_ready, m_ser_out, m_ser_valid, m_frame_start, m_frame_end, m_word_done, m_busy;
    logic l_in_ready, l_ser_out, l_ser_valid, l_frame_start, l_frame_end, l_word_done, l_busy;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    piso_stream #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
        .clock(clock), .reset(reset), .par_in(par_in), .in_valid(in_valid),
        .in_ready(m_in_ready), .shift_en(shift_en), .ser_out(m_ser_out),
        .ser_valid(m_ser_valid), .frame_start(m_frame_start), .frame_end(m_frame_end),
        .word_done(m_word_done), .busy(m_busy)
    );

    piso_stream #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_lsb (
        .clock(clock), .reset(reset), .par_in(par_in), .in_valid(in_valid),
        .in_ready(l_in_ready), .shift_en(shift_en), .ser_out(l_ser_out),
        .ser_valid(l_ser_valid), .frame_start(l_frame_start), .frame_end(l_frame_end),
        .word_done(l_word_done), .busy(l_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Load w into an idle MSB-first shifter; each bit is held for pace cycles.
    task automatic run_word(input logic [7:0] w, input int pace);
        par_in   = w;
        in_valid = 1'b1;
        shift_en = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            for (int c = 0; c < pace; c++) begin
                shift_en = (c == pace - 1);
                check("bit", m_ser_out, w[7-k]);
                check("valid", m_ser_valid, 1);
                check("fstart", m_frame_start, k == 0);
                check("fend", m_frame_end, k == 7);
                check("wdone_mid", m_word_done, 0);
                tick();
            end
        end
        check("wdone_pulse", m_word_done, 1);
        check("valid_after", m_ser_valid, 0);
        check("idle_out", m_ser_out, 0);
        check("busy_after", m_busy, 0);
        shift_en = 1'b0;
        tick();
        check("wdone_clear", m_word_done, 0);
    endtask

    initial begin
        logic [15:0] pair;

        reset = 1'b1;
        tick();
        tick();
        check("rst_out", m_ser_out, 0);
        check("rst_valid", m_ser_valid, 0);
        check("rst_ready", m_in_ready, 1);
        check("rst_fstart", m_frame_start, 0);
        check("rst_fend", m_frame_end, 0);
        check("rst_busy", m_busy, 0);
        check("rst_wdone", m_word_done, 0);
        check("rst_l_out", l_ser_out, 1);
        reset = 1'b0;
        tick();

        run_word(8'hA5, 1);
        run_word(8'hC3, 4);

        // LSB-first, idle-high instance
        check("l_idle_before", l_ser_out, 1);
        check("l_valid_before", l_ser_valid, 0);
        par_in = 8'h01; in_valid = 1'b1; shift_en = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("l_bit", l_ser_out, k == 0);
            check("l_valid", l_ser_valid, 1);
            tick();
        end
        check("l_wdone", l_word_done, 1);
        check("l_idle_after", l_ser_out, 1);
        check("l_valid_after", l_ser_valid, 0);
        tick();

        // Back-to-back through the hold register
        pair = 16'hA53C;
        par_in = 8'hA5; in_valid = 1'b1; shift_en = 1'b1;
        tick();
        par_in = 8'h3C;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k < 16; k++) begin
            check("b2b_bit", m_ser_out, pair[15-k]);
            check("b2b_valid", m_ser_valid, 1);
            check("b2b_ready", m_in_ready, (k >= 1 && k <= 7) ? 0 : 1);
            check("b2b_wdone", m_word_done, k == 8);
            tick();
        end
        check("b2b_wdone2", m_word_done, 1);
        check("b2b_end_valid", m_ser_valid, 0);
        tick();

        // Accept exactly on the last-bit edge with hold empty
        par_in = 8'hA5; in_valid = 1'b1; shift_en = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k == 7) begin
                par_in = 8'h3C;
                in_valid = 1'b1;
            end
            check("direct_ready", m_in_ready, 1);
            tick();
        end
        in_valid = 1'b0;
        pair = 16'h3C00;
        check("direct_wdone", m_word_done, 1);
        check("direct_ready_after", m_in_ready, 1);
        for (int k = 0; k < 8; k++) begin
            check("direct_bit", m_ser_out, pair[15-k]);
            check("direct_valid", m_ser_valid, 1);
            check("direct_nohold", m_in_ready, 1);
            tick();
        end
        check("direct_end", m_ser_valid, 0);
        tick();

        // Reset mid-word with a word in hold
        par_in = 8'hFF; in_valid = 1'b1; shift_en = 1'b1;
        tick();
        par_in = 8'h00;
        tick();
        in_valid = 1'b0;
        check("pre_rst_ready", m_in_ready, 0);
        tick();
        tick();
        #2 reset = 1'b1;
        #1;
        check("mid_rst_out", m_ser_out, 0);
        check("mid_rst_valid", m_ser_valid, 0);
        check("mid_rst_ready", m_in_ready, 1);
        check("mid_rst_busy", m_busy, 0);
        check("mid_rst_fstart", m_frame_start, 0);
        check("mid_rst_fend", m_frame_end, 0);
        check("mid_rst_wdone", m_word_done, 0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_wdone", m_word_done, 0);
        check("post_rst_valid", m_ser_valid, 0);
        run_word(8'h81, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
